uart_dbg_responder: RTL and testbench

On-chip responder for the UART debug protocol spoken by the host-side debug initiator (command bytes 0x11 read, 0x12 write, 0x13 exec; replies 0x06 ack, 0x04 abort, 0x14 end-of-code).
- Sits between the SoC UART byte-level RX/TX datapath and a 32-bit OBI manager port on the main crossbar.
- Decodes command frames, performs single-word bus accesses, and returns acknowledgements and read data.
- Reports the core exit code once the core status register becomes non-zero.

---
 rtl/uart_dbg_responder.sv | 208 ++++++++++++++++++++
 tb/tb_uart_dbg_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dbg_responder.sv
// UART debug-protocol responder: decodes read/write/exec frames from the byte
// stream, performs single-word OBI accesses and reports the core exit code once.
module uart_dbg_responder #(
    parameter logic [31:0] BootAddrAddr  = 32'h0300_0000,
    parameter logic [31:0] FetchEnAddr   = 32'h0300_0004,
    parameter int unsigned TimeoutCycles = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,
    input  logic [31:0] core_status_i,
    output logic        busy_o,
    output logic        drop_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_RESP_WAIT,
        ST_SEND,
        ST_EOC
    } state_t;

    localparam logic [7:0] OpRead   = 8'h11;
    localparam logic [7:0] OpWrite  = 8'h12;
    localparam logic [7:0] OpExec   = 8'h13;
    localparam logic [7:0] RspAck   = 8'h06;
    localparam logic [7:0] RspAbort = 8'h04;
    localparam logic [7:0] RspEoc   = 8'h14;

    state_t      state;
    logic [7:0]  opcode;
    logic [1:0]  byte_cnt;
    logic [23:0] addr_q;
    logic [23:0] data_q;
    logic [31:0] tmo_cnt;
    logic        fe_phase;
    logic [31:0] tx_buf;
    logic [2:0]  tx_rem;
    logic        eoc_sent;
    logic        drop_q;

    // Only the first three bytes are stored; the fourth is combined on arrival.
    logic [31:0] addr_full;
    logic [31:0] data_full;
    logic        tmo_hit;

    assign addr_full = {rx_data_i, addr_q};
    assign data_full = {rx_data_i, data_q};
    assign tmo_hit   = (TimeoutCycles != 0) && (tmo_cnt == TimeoutCycles - 1);

    assign obi_be_o = 4'hF;
    assign busy_o   = (state != ST_IDLE);
    assign drop_o   = drop_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            opcode      <= '0;
            byte_cnt    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tmo_cnt     <= '0;
            fe_phase    <= 1'b0;
            tx_buf      <= '0;
            tx_rem      <= '0;
            eoc_sent    <= 1'b0;
            drop_q      <= 1'b0;
            tx_data_o   <= '0;
            tx_valid_o  <= 1'b0;
            obi_req_o   <= 1'b0;
            obi_addr_o  <= '0;
            obi_we_o    <= 1'b0;
            obi_wdata_o <= '0;
        end else begin
            if (rx_valid_i && (state == ST_REQ || state == ST_RESP_WAIT ||
                               state == ST_SEND || state == ST_EOC)) begin
                drop_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == OpRead || rx_data_i == OpWrite || rx_data_i == OpExec) begin
                            opcode   <= rx_data_i;
                            byte_cnt <= '0;
                            tmo_cnt  <= '0;
                            fe_phase <= 1'b0;
                            state    <= ST_ADDR;
                        end
                    end else if (core_status_i != '0 && !eoc_sent) begin
                        tx_data_o  <= RspEoc;
                        tx_valid_o <= 1'b1;
                        tx_buf     <= core_status_i;
                        tx_rem     <= 3'd4;
                        state      <= ST_EOC;
                    end
                end

                ST_ADDR, ST_DATA: begin
                    if (rx_valid_i) begin
                        tmo_cnt  <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == ST_ADDR) begin
                            addr_q <= {rx_data_i, addr_q[23:8]};
                        end else begin
                            data_q <= {rx_data_i, data_q[23:8]};
                        end
                        if (byte_cnt == 2'd3) begin
                            if (state == ST_DATA) begin
                                obi_we_o    <= 1'b1;
                                obi_wdata_o <= data_full;
                                obi_req_o   <= 1'b1;
                                state       <= ST_REQ;
                            end else if (opcode == OpWrite) begin
                                obi_addr_o <= {addr_full[31:2], 2'b00};
                                state      <= ST_DATA;
                            end else if (opcode == OpExec) begin
                                obi_addr_o  <= {BootAddrAddr[31:2], 2'b00};
                                obi_we_o    <= 1'b1;
                                obi_wdata_o <= addr_full;
                                obi_req_o   <= 1'b1;
                                state       <= ST_REQ;
                            end else begin
                                obi_addr_o <= {addr_full[31:2], 2'b00};
                                obi_we_o   <= 1'b0;
                                obi_req_o  <= 1'b1;
                                state      <= ST_REQ;
                            end
                        end
                    end else if (tmo_hit) begin
                        tx_data_o  <= RspAbort;
                        tx_valid_o <= 1'b1;
                        tx_rem     <= '0;
                        state      <= ST_SEND;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                ST_REQ: begin
                    if (obi_gnt_i) begin
                        obi_req_o <= 1'b0;
                        state     <= ST_RESP_WAIT;
                    end
                end

                ST_RESP_WAIT: begin
                    if (obi_rvalid_i) begin
                        if (obi_err_i) begin
                            tx_data_o  <= RspAbort;
                            tx_valid_o <= 1'b1;
                            tx_rem     <= '0;
                            state      <= ST_SEND;
                        end else if (opcode == OpExec && !fe_phase) begin
                            fe_phase    <= 1'b1;
                            obi_addr_o  <= {FetchEnAddr[31:2], 2'b00};
                            obi_wdata_o <= 32'h1;
                            obi_req_o   <= 1'b1;
                            state       <= ST_REQ;
                        end else begin
                            tx_data_o  <= RspAck;
                            tx_valid_o <= 1'b1;
                            tx_buf     <= obi_rdata_i;
                            tx_rem     <= (opcode == OpRead) ? 3'd4 : 3'd0;
                            state      <= ST_SEND;
                        end
                    end
                end

                ST_SEND, ST_EOC: begin
                    // Remaining reply bytes are shifted out of tx_buf LSB first.
                    if (tx_ready_i) begin
                        if (tx_rem != '0) begin
                            tx_data_o <= tx_buf[7:0];
                            tx_buf    <= {8'h00, tx_buf[31:8]};
                            tx_rem    <= tx_rem - 3'd1;
                        end else begin
                            tx_valid_o <= 1'b0;
                            state      <= ST_IDLE;
                            if (state == ST_EOC) begin
                                eoc_sent <= 1'b1;
                            end
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dbg_responder.sv
// Scoreboard bench for uart_dbg_responder: directed frames, OBI memory model,
// reply/bus monitors comparing against queued expectations.
module tb_uart_dbg_responder;

    localparam logic [31:0] BOOT = 32'h0300_0000;
    localparam logic [31:0] FE   = 32'h0300_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready;
    logic        obi_req_o;
    logic        obi_gnt;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        obi_err;
    logic [31:0] core_status;
    logic        busy_o;
    logic        drop_o;

    always #5 clk = ~clk;

    uart_dbg_responder #(
        .BootAddrAddr (BOOT),
        .FetchEnAddr  (FE),
        .TimeoutCycles(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid),
        .obi_rdata_i  (obi_rdata),
        .obi_err_i    (obi_err),
        .core_status_i(core_status),
        .busy_o       (busy_o),
        .drop_o       (drop_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wdata;
        int unsigned hold;
    } bus_exp_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  exp_tx[$];
    bus_exp_t    exp_bus[$];

    int unsigned gnt_delay  = 0;
    logic        bus_err    = 1'b0;
    int unsigned ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reply monitor: every accepted byte must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && tx_valid_o && tx_ready) begin
            if (exp_tx.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_unexpected: got %h, expected no byte", tx_data_o);
            end else begin
                check("tx_byte", 64'(tx_data_o), 64'(exp_tx.pop_front()));
            end
        end
    end

    // Bus monitor: fields stable while requesting, compared at grant.
    logic [64:0] held;
    int unsigned hold_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_cnt = 0;
        end else if (obi_req_o) begin
            if (hold_cnt == 0) held = {obi_addr_o, obi_we_o, obi_wdata_o};
            else check("req_stable", 64'({obi_addr_o, obi_we_o, obi_wdata_o} ^ held), 64'(0));
            hold_cnt++;
            if (obi_gnt) begin
                if (exp_bus.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL bus_unexpected: got addr %h, expected no access", obi_addr_o);
                end else begin
                    bus_exp_t e;
                    e = exp_bus.pop_front();
                    check("bus_addr", 64'(obi_addr_o), 64'(e.addr));
                    check("bus_we", 64'(obi_we_o), 64'(e.we));
                    if (e.chk_wdata) check("bus_wdata", 64'(obi_wdata_o), 64'(e.wdata));
                    check("bus_hold", 64'(hold_cnt), 64'(e.hold));
                    check("bus_be", 64'(obi_be_o), 64'(4'hF));
                end
                hold_cnt = 0;
            end
        end
    end

    // OBI memory: grant after gnt_delay request cycles, respond the next cycle.
    logic [31:0] mem [logic [31:0]];
    initial begin
        logic        pend;
        logic [31:0] p_addr, p_wdata;
        logic        p_we;
        int unsigned wait_cnt;
        pend = 0; wait_cnt = 0; p_addr = '0; p_wdata = '0; p_we = 0;
        obi_gnt = 0; obi_rvalid = 0; obi_rdata = '0; obi_err = 0;
        forever begin
            @(posedge clk); #1;
            obi_rvalid = 0;
            obi_err    = 0;
            obi_gnt    = 0;
            if (!rst_n) begin
                pend = 0;
                wait_cnt = 0;
            end else begin
                if (pend) begin
                    obi_rvalid = 1;
                    obi_err    = bus_err;
                    if (p_we) mem[p_addr] = p_wdata;
                    else obi_rdata = mem.exists(p_addr) ? mem[p_addr] : 32'hDEAD_BEEF;
                    pend = 0;
                end
                if (obi_req_o) begin
                    if (wait_cnt >= gnt_delay) begin
                        obi_gnt  = 1;
                        pend     = 1;
                        p_addr   = obi_addr_o;
                        p_we     = obi_we_o;
                        p_wdata  = obi_wdata_o;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        tx_ready = 1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       tx_ready = 1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 0;
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1;
        @(posedge clk); #1;
        rx_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic exp_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                              input logic chk, input int unsigned hold);
        bus_exp_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.chk_wdata = chk; e.hold = hold;
        exp_bus.push_back(e);
    endtask

    task automatic exp_bytes(input logic [7:0] b0, input logic [31:0] w);
        exp_tx.push_back(b0);
        for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name, input int unsigned bound);
        for (int unsigned i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (exp_tx.size() == 0 && exp_bus.size() == 0 && !busy_o && !tx_valid_o) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d replies/%0d accesses outstanding, expected none", name,
                 exp_tx.size(), exp_bus.size());
        exp_tx.delete();
        exp_bus.delete();
    endtask

    task automatic wait_tx_valid(input string name, input int unsigned bound);
        for (int unsigned i = 0; i < bound; i++) begin
            if (tx_valid_o) return;
            @(posedge clk); #1;
        end
        check(name, 64'(tx_valid_o), 64'(1));
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctl"}, 64'({tx_valid_o, obi_req_o, obi_we_o, busy_o, drop_o, tx_data_o, obi_be_o}),
              64'({5'b0, 8'h00, 4'hF}));
        check({name, "_bus"}, {obi_addr_o, obi_wdata_o}, 64'(0));
    endtask

    task automatic do_reset(input string name);
        rst_n = 0;
        @(posedge clk); #1;
        exp_tx.delete();
        exp_bus.delete();
        check_reset(name);
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        int unsigned k;
        rst_n = 0; rx_valid = 0; rx_data = '0; core_status = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_init");
        rst_n = 1;

        // Non-command byte in IDLE: silently ignored.
        send_byte(8'h55);
        repeat (4) @(posedge clk);
        #1;
        check("idle_ignore_drop", 64'(drop_o), 64'(0));
        check("idle_ignore_busy", 64'(busy_o), 64'(0));

        // Write then read back, zero-wait memory.
        exp_access(32'h1000_0000, 1, 32'h1234_5678, 1, 1);
        exp_tx.push_back(8'h06);
        send_byte(8'h12); send_word(32'h1000_0000); send_word(32'h1234_5678);
        @(negedge clk);
        check("req_latency", 64'(obi_req_o), 64'(1));
        @(negedge clk); @(negedge clk);
        check("reply_latency", 64'({tx_valid_o, tx_data_o}), 64'({1'b1, 8'h06}));
        wait_idle("write_done", 200);

        exp_access(32'h1000_0000, 0, '0, 0, 1);
        exp_bytes(8'h06, 32'h1234_5678);
        send_byte(8'h11); send_word(32'h1000_0000);
        wait_idle("read_done", 200);

        // Exec: boot address, then fetch enable.
        exp_access(BOOT, 1, 32'h1000_0080, 1, 1);
        exp_access(FE, 1, 32'h1, 1, 1);
        exp_tx.push_back(8'h06);
        send_byte(8'h13); send_word(32'h1000_0080);
        wait_idle("exec_done", 200);

        // Unaligned read, slow grant, error response.
        gnt_delay = 5; bus_err = 1;
        exp_access(32'h0000_0000, 0, '0, 0, 6);
        exp_tx.push_back(8'h04);
        send_byte(8'h11); send_word(32'h0000_0003);
        wait_idle("err_done", 200);
        gnt_delay = 0; bus_err = 0;

        // Timeout mid-frame.
        exp_tx.push_back(8'h04);
        send_byte(8'h12); send_byte(8'hAA); send_byte(8'hBB);
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            k++;
            if (tx_valid_o) break;
        end
        check("timeout_latency", 64'(k), 64'(17));
        wait_idle("timeout_done", 200);
        exp_access(32'h1000_0000, 0, '0, 0, 1);
        exp_bytes(8'h06, 32'h1234_5678);
        send_byte(8'h11); send_word(32'h1000_0000);
        wait_idle("post_timeout_read", 200);

        // Exit code raised during an in-flight read; reported once after the reply.
        ready_mode = 1;
        exp_access(32'h1000_0000, 0, '0, 0, 1);
        exp_bytes(8'h06, 32'h1234_5678);
        exp_bytes(8'h14, 32'h0000_0001);
        send_byte(8'h11); send_word(32'h1000_0000);
        core_status = 32'h0000_0001;
        wait_idle("eoc_done", 300);
        repeat (40) @(posedge clk);
        #1;
        check("eoc_once_busy", 64'(busy_o), 64'(0));
        ready_mode = 0;

        // Stray byte while the reply is stalled.
        ready_mode = 2;
        exp_access(32'h1000_0000, 0, '0, 0, 1);
        exp_bytes(8'h06, 32'h1234_5678);
        send_byte(8'h11); send_word(32'h1000_0000);
        wait_tx_valid("stray_wait_tx", 50);
        check("drop_before", 64'(drop_o), 64'(0));
        send_byte(8'h55);
        check("drop_sticky", 64'(drop_o), 64'(1));
        ready_mode = 0;
        wait_idle("stray_done", 200);
        check("drop_stays", 64'(drop_o), 64'(1));
        core_status = '0;

        // Reset in DATA, then a fresh read.
        send_byte(8'h12); send_word(32'h1000_0000); send_byte(8'h01); send_byte(8'h02);
        check("busy_in_data", 64'(busy_o), 64'(1));
        do_reset("reset_data");
        exp_access(32'h1000_0000, 0, '0, 0, 1);
        exp_bytes(8'h06, 32'h1234_5678);
        send_byte(8'h11); send_word(32'h1000_0000);
        wait_idle("after_reset_data", 200);

        // Reset in SEND, then a fresh read.
        ready_mode = 2;
        exp_access(32'h1000_0000, 0, '0, 0, 1);
        send_byte(8'h11); send_word(32'h1000_0000);
        wait_tx_valid("send_wait_tx", 50);
        check("send_hold", 64'(tx_data_o), 64'(8'h06));
        do_reset("reset_send");
        ready_mode = 0;
        exp_access(32'h1000_0000, 0, '0, 0, 1);
        exp_bytes(8'h06, 32'h1234_5678);
        send_byte(8'h11); send_word(32'h1000_0000);
        wait_idle("after_reset_send", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
